// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts fetch requests over valid/ready,
// reads the word array, carries {err, word} through a fixed-latency pipeline
// and buffers it in a response FIFO. Credits bound the requests outstanding,
// so core back-pressure never drops a response.
module imem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam int unsigned PW   = $clog2(RFIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  // Request decode; the subtraction wraps, so addresses below the base fail the range test
  logic [31:0]   req_off;
  logic          req_err;
  logic [IW-1:0] req_idx;
  logic [31:0]   req_word;
  logic          accept;

  assign req_off  = req_addr - BASE_ADDR;
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_off >= SPAN);
  assign req_idx  = req_off[IW+1:2];
  assign req_word = req_err ? 32'h0 : mem[req_idx];
  assign accept   = req_valid && req_ready;

  // Loader decode
  logic [31:0]   load_off;
  logic          load_ok;
  logic [IW-1:0] load_idx;

  assign load_off = load_addr - BASE_ADDR;
  assign load_ok  = load_en && (load_addr[1:0] == 2'b00) && (load_off < SPAN);
  assign load_idx = load_off[IW+1:2];

  // Memory write; the fetch read above is taken before this edge, giving read-before-write
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  // Pipeline stage valid bits
  logic [LATENCY-1:0] st_valid_q;
  logic [LATENCY-1:0] st_err_q;
  logic [31:0]        st_word_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid_q <= '0;
    end else begin
      st_valid_q[0] <= accept;
      for (int i = 1; i < int'(LATENCY); i++) begin
        st_valid_q[i] <= st_valid_q[i-1];
      end
    end
  end

  // Pipeline stage payload; no reset needed, qualified by st_valid_q
  always_ff @(posedge clk) begin
    st_err_q[0]  <= req_err;
    st_word_q[0] <= req_word;
    for (int i = 1; i < int'(LATENCY); i++) begin
      st_err_q[i]  <= st_err_q[i-1];
      st_word_q[i] <= st_word_q[i-1];
    end
  end

  // Response FIFO with one extra pointer bit to tell full from empty
  logic [32:0] fifo_q [RFIFO_DEPTH];
  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // Credits guarantee space; the full gate is only a backstop
  assign push       = st_valid_q[LATENCY-1] && !fifo_full;
  assign pop        = resp_valid && resp_ready;

  // FIFO pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= {st_err_q[LATENCY-1], st_word_q[LATENCY-1]};
    end
  end

  assign resp_valid = !fifo_empty;
  assign {resp_err, resp_inst} = fifo_empty ? 33'h0 : fifo_q[rd_ptr_q[PW-1:0]];

  // Credits count in-flight stages plus FIFO occupancy
  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;

  // Next credit count; accept and pop together cancel
  always_comb begin
    credit_d = credit_q;
    unique case ({accept, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // Credit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign req_ready = !rst && (credit_q < CW'(RFIFO_DEPTH));
  assign busy      = (credit_q != '0);

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: address table, back-pressure, credit, reset and
// load/fetch collision sequences, with a scoreboard on every popped response.
module tb_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy;

  imem_resp dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_inst (resp_inst),
    .resp_err  (resp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  logic [31:0] mdl [1024];
  logic [32:0] sb [$];
  logic [31:0] words [8];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'd4096);
  endfunction

  function automatic logic [32:0] model_resp(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (in_range(a)) return {1'b0, mdl[off[11:2]]};
    return {1'b1, 32'h0};
  endfunction

  // Scoreboard: pop/compare, push expectation, then apply loads (read-before-write)
  always @(negedge clk) begin
    logic [31:0] off;
    logic [32:0] exp;
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got %h expected none", {resp_err, resp_inst});
        end else begin
          exp = sb.pop_front();
          chk("resp_order", {resp_err, resp_inst}, exp);
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        sb.push_back(model_resp(req_addr));
      end
      if (load_en && in_range(load_addr)) begin
        off = load_addr - BASE;
        mdl[off[11:2]] = load_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    logic got;
    logic ok;
    got = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      ok = req_ready;
      tick();
      if (ok) got = 1'b1;
    end
    req_valid = 1'b0;
    chk("send_timeout", {32'h0, got}, 33'h1);
  endtask

  task automatic wait_resp(output logic [31:0] inst, output logic err);
    logic got;
    got = 1'b0;
    inst = 32'h0;
    err = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (resp_valid) begin
        inst = resp_inst;
        err = resp_err;
        got = 1'b1;
      end else begin
        tick();
      end
    end
    chk("resp_timeout", {32'h0, got}, 33'h1);
    tick();
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && busy; c++) tick();
    chk("drain_busy", {32'h0, busy}, 33'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] inst;
    logic        err;
    int a0;
    int p0;

    words[0] = 32'h0010_0093;
    words[1] = 32'h0000_0013;
    for (int i = 2; i < 8; i++) words[i] = 32'hA5A5_0000 | 32'(i);

    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0000_0013, 1'b0};
    vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h8000_1000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h8000_0FFC, 32'hCAFE_F00D, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'h0;
    resp_ready = 1'b1;
    load_en = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
    tick();
    tick();
    chk("rst_req_ready", {32'h0, req_ready}, 33'h0);
    chk("rst_resp_valid", {32'h0, resp_valid}, 33'h0);
    chk("rst_resp", {resp_err, resp_inst}, 33'h0);
    chk("rst_busy", {32'h0, busy}, 33'h0);
    rst = 1'b0;
    tick();
    chk("rel_req_ready", {32'h0, req_ready}, 33'h1);

    for (int i = 0; i < 8; i++) do_load(BASE + 32'(4 * i), words[i]);
    do_load(32'h8000_0FFC, 32'hCAFE_F00D);
    // Rejected loads: misaligned and out of range must not alias onto word 0
    do_load(32'h8000_0001, 32'hFFFF_FFFF);
    do_load(32'h8000_1000, 32'hFFFF_FFFF);

    // Table: exact two-cycle latency and result per address
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].addr);
      chk("lat_n", {32'h0, resp_valid}, 33'h0);
      tick();
      chk("lat_n1", {32'h0, resp_valid}, 33'h0);
      tick();
      chk("lat_n2", {32'h0, resp_valid}, 33'h1);
      chk("vec_resp", {resp_err, resp_inst}, {vecs[i].err, vecs[i].inst});
      tick();
      chk("vec_done", {32'h0, resp_valid}, 33'h0);
    end

    // Back-to-back requests
    req_valid = 1'b1;
    req_addr = BASE;
    tick();
    req_addr = BASE + 32'd4;
    tick();
    req_valid = 1'b0;
    chk("b2b_gap", {32'h0, resp_valid}, 33'h0);
    tick();
    chk("b2b_first", {resp_valid, resp_inst}, {1'b1, words[0]});
    tick();
    chk("b2b_second", {resp_valid, resp_inst}, {1'b1, words[1]});
    tick();
    chk("b2b_idle", {32'h0, resp_valid}, 33'h0);

    // Back-pressure: exactly four accepts, stable head
    resp_ready = 1'b0;
    req_valid = 1'b1;
    a0 = acc_cnt;
    p0 = pop_cnt;
    for (int c = 0; c < 10; c++) begin
      req_addr = BASE + 32'(4 * (acc_cnt - a0));
      tick();
      if (c >= 3) chk("hold_head", {resp_valid, resp_inst}, {1'b1, words[0]});
    end
    chk("bp_accepts", 33'(acc_cnt - a0), 33'd4);
    chk("bp_ready", {32'h0, req_ready}, 33'h0);
    chk("bp_busy", {32'h0, busy}, 33'h1);
    req_addr = BASE + 32'd16;
    resp_ready = 1'b1;
    tick();
    chk("pop_reassert", {32'h0, req_ready}, 33'h1);
    chk("pop_noaccept", 33'(acc_cnt - a0), 33'd4);
    tick();
    chk("pop_and_accept", 33'(acc_cnt - a0), 33'd5);
    chk("pop_accept_ready", {32'h0, req_ready}, 33'h1);
    // Credits must now be 3: exactly one more accept fits
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_addr = BASE + 32'(4 * (acc_cnt - a0));
      tick();
    end
    chk("credit_refill", 33'(acc_cnt - a0), 33'd6);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    chk("bp_pops", 33'(pop_cnt - p0), 33'd6);

    // Reset with requests in flight
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = BASE + 32'd8;
    tick();
    req_addr = BASE + 32'd12;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {32'h0, resp_valid}, 33'h1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_valid", {32'h0, resp_valid}, 33'h0);
    chk("mid_rst_busy", {32'h0, busy}, 33'h0);
    chk("mid_rst_ready", {32'h0, req_ready}, 33'h0);
    tick();
    tick();
    rst = 1'b0;
    p0 = pop_cnt;
    resp_ready = 1'b1;
    send(BASE + 32'd4);
    wait_resp(inst, err);
    chk("post_rst_word", {err, inst}, {1'b0, words[1]});
    for (int c = 0; c < 5; c++) tick();
    chk("post_rst_pops", 33'(pop_cnt - p0), 33'd1);

    // Same-cycle load and fetch of one word
    req_valid = 1'b1;
    req_addr = BASE + 32'd8;
    load_en = 1'b1;
    load_addr = BASE + 32'd8;
    load_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    load_en = 1'b0;
    wait_resp(inst, err);
    chk("rbw_old", {err, inst}, {1'b0, words[2]});
    send(BASE + 32'd8);
    wait_resp(inst, err);
    chk("rbw_new", {err, inst}, {1'b0, 32'hDEAD_BEEF});
    drain();

    chk("sb_empty", 33'(sb.size()), 33'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
